// File: rtl/rng_uart_tx.sv
// rtl/rng_uart_tx.sv - 8N1 UART transmitter with a 4-byte input FIFO for an RNG core
//
// Purpose: serialises random bytes from an upstream generator onto an 8N1
// line (idle high, LSB first) and keeps the last four transmitted bytes
// for a hex display.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-low reset
//   in_data    byte offered by the generator
//   in_valid   in_data valid this cycle
//   in_ready   a byte can be accepted this cycle
//   TxD        registered serial output
//   busy       frame in progress or bytes queued
//   disp_word  last four transmitted bytes, newest in [7:0]

module rng_uart_tx #(
   parameter int comm_clk_frequency = 50_000_000,
   parameter int baud_rate          = 115200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        TxD,
   output logic        busy,
   output logic [31:0] disp_word
);

   localparam int DIV   = comm_clk_frequency / baud_rate;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   generate
      if (DIV < 2) begin : g_div_check
         $error("rng_uart_tx: clock/baud ratio must be at least 2");
      end
   endgenerate

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic [31:0]      disp_word_q, disp_word_d;

   logic [7:0]       mem_q [4];
   logic [7:0]       mem_d [4];
   logic [1:0]       wr_ptr_q, wr_ptr_d;
   logic [1:0]       rd_ptr_q, rd_ptr_d;
   logic [2:0]       count_q, count_d;

   logic             push;
   logic             pop;
   logic             bit_done;

   // Ready depends only on the registered count, so a pop in the same
   // cycle cannot make room for a push while full. The reset term keeps
   // the port low while reset is held; reset is synchronous to clk.
   assign in_ready  = reset && (count_q < 3'd4);
   assign push      = in_valid && in_ready;
   assign bit_done  = (bit_cnt_q == CNT_LAST);

   assign TxD       = txd_q;
   assign busy      = (state_q != ST_IDLE) || (count_q != 3'd0);
   assign disp_word = disp_word_q;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      disp_word_d = disp_word_q;
      pop         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (count_q != 3'd0) begin
               pop         = 1'b1;
               shift_d     = mem_q[rd_ptr_q];
               disp_word_d = {disp_word_q[23:0], mem_q[rd_ptr_q]};
               bit_cnt_d   = '0;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (bit_done) begin
               bit_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      endcase

      // Line level follows the next state so the start bit appears on the
      // edge that pops the byte.
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[bit_idx_d];
         default:  txd_d = 1'b1;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         bit_idx_q   <= 3'd0;
         shift_q     <= 8'h00;
         txd_q       <= 1'b1;
         disp_word_q <= 32'h0;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         count_q     <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         txd_q       <= txd_d;
         disp_word_q <= disp_word_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rng_uart_tx.sv
// tb/tb_rng_uart_tx.sv - self-checking bench for rng_uart_tx

module tb_rng_uart_tx;

   localparam int DIV = 10;

   logic        clk;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        TxD;
   logic        busy;
   logic [31:0] disp_word;

   rng_uart_tx #(
      .comm_clk_frequency(1000),
      .baud_rate(100)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .TxD(TxD),
      .busy(busy),
      .disp_word(disp_word)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: bytes waiting, the byte on the wire and the edge its frame began.
   int          cyc_n = 0;
   logic [7:0]  m_q[$];
   bit          f_act = 0;
   int          f_s = 0;
   logic [7:0]  f_b = 8'h00;
   logic [31:0] m_disp = 32'h0;
   bit          m_pushed = 0;

   bit          chk_en = 0;
   bit          dec_en = 0;
   logic        txd_hist [0:39999];
   int          fall_q[$];
   logic [7:0]  dec_q[$];
   logic [7:0]  sent_q[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, cyc_n);
      end
   endtask

   function automatic bit m_active();
      return f_act && (cyc_n < f_s + 10 * DIV);
   endfunction

   function automatic logic m_txd();
      int slot;
      if (!m_active()) return 1'b1;
      slot = (cyc_n - f_s) / DIV;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return f_b[slot-1];
   endfunction

   function automatic bit m_busy();
      return m_active() || (m_q.size() > 0);
   endfunction

   task automatic model_edge();
      bit p_push;
      bit p_pop;
      cyc_n++;
      m_pushed = 0;
      if (!reset) begin
         m_q.delete();
         f_act  = 0;
         m_disp = 32'h0;
         return;
      end
      p_push = in_valid && (m_q.size() < 4);
      p_pop  = (m_q.size() > 0) && (!f_act || cyc_n >= f_s + 10 * DIV + 1);
      if (p_pop) begin
         f_b    = m_q.pop_front();
         f_s    = cyc_n;
         f_act  = 1;
         m_disp = {m_disp[23:0], f_b};
      end
      if (p_push) m_q.push_back(in_data);
      m_pushed = p_push;
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic r);
      #1;
      in_valid = v;
      in_data  = d;
      reset    = r;
      @(posedge clk);
      model_edge();
   endtask

   task automatic send_byte(input logic [7:0] b, output int acc_n);
      int n = 0;
      acc_n = -1;
      do begin
         cyc(1'b1, b, 1'b1);
         n++;
      end while (!m_pushed && n < 2000);
      if (m_pushed) acc_n = cyc_n;
      else chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      do begin
         cyc(1'b0, 8'h00, 1'b1);
         n++;
      end while (m_busy() && n < 3000);
      if (m_busy()) chk("drain_timeout", 32'd0, 32'd1);
      repeat (2) cyc(1'b0, 8'h00, 1'b1);
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("txd", 32'(TxD), 32'(m_txd()));
         chk("busy", 32'(busy), 32'(m_busy()));
         chk("in_ready", 32'(in_ready), 32'(reset && (m_q.size() < 4)));
         chk("disp_word", disp_word, m_disp);
         if (cyc_n < 40000) txd_hist[cyc_n] <= TxD;
      end
   end

   // Independent UART receiver sampling at bit centres.
   logic       d_act = 0;
   int         d_cnt = 0;
   logic [7:0] d_byte = 8'h00;

   always @(negedge clk) begin
      if (!chk_en) begin
         d_act <= 0;
      end else if (!d_act) begin
         if (TxD == 1'b0) begin
            d_act <= 1;
            d_cnt <= 1;
            fall_q.push_back(cyc_n);
         end
      end else begin
         if (d_cnt % DIV == DIV / 2) begin
            if (d_cnt / DIV == 0) begin
               if (dec_en) chk("start_bit", 32'(TxD), 32'd0);
            end else if (d_cnt / DIV <= 8) begin
               d_byte[3'(d_cnt / DIV - 1)] <= TxD;
            end else begin
               if (dec_en) begin
                  chk("stop_bit", 32'(TxD), 32'd1);
                  dec_q.push_back(d_byte);
               end
               d_act <= 0;
            end
         end
         d_cnt <= d_cnt + 1;
      end
   end

   initial begin
      int         e_a5;
      int         acc [1:6];
      int         f0;
      int         f1;
      int         fs;
      int         dummy;
      logic [9:0] pat;
      logic [7:0] rb;

      clk      = 1'b0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      cyc(1'b0, 8'h00, 1'b0);
      chk_en = 1;
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      @(negedge clk); #1;
      chk("rst_txd", 32'(TxD), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_disp", disp_word, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);

      cyc(1'b0, 8'h00, 1'b1);
      @(negedge clk); #1;
      chk("ready_after_release", 32'(in_ready), 32'd1);

      // Single byte 0xA5: start, LSB-first data, stop.
      send_byte(8'hA5, e_a5);
      drain();
      pat = 10'b1101001010;
      chk("a5_idle_at_accept", 32'(txd_hist[e_a5]), 32'd1);
      chk("a5_low_next_edge", 32'(txd_hist[e_a5+1]), 32'd0);
      for (int j = 0; j < 10; j++) begin
         chk("a5_bit_centre", 32'(txd_hist[e_a5 + 1 + j * DIV + DIV / 2]), 32'(pat[j]));
      end
      chk("a5_disp", disp_word, 32'h000000A5);

      // Six bytes with in_valid held high; the sixth waits for a pop.
      f0 = fall_q.size();
      for (int i = 1; i <= 6; i++) send_byte(8'(i), acc[i]);
      drain();
      chk("burst_acc5", 32'(acc[5] - acc[1]), 32'd4);
      chk("burst_acc6", 32'(acc[6] - acc[1]), 32'd103);
      chk("burst_frames", 32'(fall_q.size() - f0), 32'd6);
      for (int k = 1; k < 6; k++) begin
         if (f0 + k < fall_q.size())
            chk("burst_spacing", 32'(fall_q[f0+k] - fall_q[f0+k-1]), 32'd101);
      end
      chk("burst_disp", disp_word, 32'h03040506);

      // Reset 35 cycles into a frame with two bytes queued.
      send_byte(8'h11, dummy);
      send_byte(8'h22, dummy);
      send_byte(8'h33, dummy);
      fs = f_s;
      while (cyc_n < fs + 34) cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0);
      @(negedge clk); #1;
      chk("abort_was_low", 32'(txd_hist[fs+34]), 32'd0);
      chk("abort_txd", 32'(TxD), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_disp", disp_word, 32'h0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      f1 = fall_q.size();

      // Long idle: nothing further on the line.
      repeat (500) cyc(1'b0, 8'h00, 1'b1);
      @(negedge clk); #1;
      chk("idle_no_frames", 32'(fall_q.size() - f1), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      // 256 random bytes through the receiver.
      dec_en = 1;
      for (int i = 0; i < 256; i++) begin
         rb = 8'($urandom_range(0, 255));
         sent_q.push_back(rb);
         send_byte(rb, dummy);
      end
      drain();
      dec_en = 0;
      chk("rand_count", 32'(dec_q.size()), 32'd256);
      for (int i = 0; i < 256; i++) begin
         if (i < dec_q.size()) chk("rand_byte", 32'(dec_q[i]), 32'(sent_q[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
